// File: rtl/hkspi_master_wb.sv
// rtl/hkspi_master_wb.sv - Wishbone-controlled SPI master for single-byte housekeeping register transfers
module hkspi_master_wb #(
    parameter logic [31:0] BASE_ADR = 32'h2600_0000,
    parameter int          CLK_DIV  = 4
) (
    input  logic        wb_clk_i,
    input  logic        resetb,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    input  logic [31:0] wb_adr_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        spi_csb,
    output logic        spi_sck,
    output logic        spi_sdi,
    input  logic        spi_sdo,
    output logic        irq
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

    state_t      state, next_state;
    logic        served;
    logic        ctrl_rw;
    logic [7:0]  ctrl_addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        done;
    logic        start_q;
    logic [23:0] shreg;
    logic [7:0]  rx;
    logic [7:0]  cnt;
    logic        phase;
    logic [4:0]  bit_cnt;
    logic [31:0] rd_val;

    // Byte selects, the upper write-data half and the byte offset are never decoded.
    logic unused_bits;
    assign unused_bits = &{1'b0, wb_sel_i, wb_dat_i[31:16], wb_adr_i[1:0]};

    logic       hit, acc, wr, busy, start_cmd, last;
    logic [1:0] reg_sel;

    assign hit       = wb_stb_i & wb_cyc_i & (wb_adr_i[31:4] == BASE_ADR[31:4]);
    assign acc       = hit & ~served;
    assign wr        = acc & wb_we_i;
    assign reg_sel   = wb_adr_i[3:2];
    // busy covers the one-cycle gap between the start write and leaving IDLE, and the DONE cycle.
    assign busy      = start_q | (state != IDLE);
    assign start_cmd = wr & (reg_sel == 2'd0) & wb_dat_i[0] & ~busy;
    assign last      = (cnt == LAST_CNT);

    assign spi_csb = ~((state == SETUP) | (state == SHIFT) | (state == HOLD));
    assign spi_sck = (state == SHIFT) & phase;
    assign spi_sdi = ((state == SETUP) | (state == SHIFT)) & shreg[23];
    assign irq     = done;

    // Register read multiplexer; unused bits read zero.
    always_comb begin
        rd_val = 32'h0;
        case (reg_sel)
            2'd0: rd_val = {16'h0, ctrl_addr, 6'h0, ctrl_rw, 1'b0};
            2'd1: rd_val = {24'h0, wdata};
            2'd2: rd_val = {24'h0, rdata};
            2'd3: rd_val = {30'h0, done, busy};
            default: rd_val = 32'h0;
        endcase
    end

    // Bus handshake: one ack per strobe, read data registered alongside it.
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'h0;
            served   <= 1'b0;
        end else begin
            wb_ack_o <= acc;
            served   <= hit;
            wb_dat_o <= (acc & ~wb_we_i) ? rd_val : 32'h0;
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) state <= IDLE;
        else         state <= next_state;
    end

    // FSM next-state: each phase is timed in units of CLK_DIV cycles by cnt.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_q) next_state = SETUP;
            SETUP:   if (last) next_state = SHIFT;
            SHIFT:   if (last && phase && (bit_cnt == 5'd23)) next_state = HOLD;
            HOLD:    if (last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registers, shift datapath and status flags.
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            ctrl_rw   <= 1'b0;
            ctrl_addr <= 8'h0;
            wdata     <= 8'h0;
            rdata     <= 8'h0;
            done      <= 1'b0;
            start_q   <= 1'b0;
            shreg     <= 24'h0;
            rx        <= 8'h0;
            cnt       <= 8'h0;
            phase     <= 1'b0;
            bit_cnt   <= 5'd0;
        end else begin
            if (start_cmd)               start_q <= 1'b1;
            else if (state == IDLE)      start_q <= 1'b0;

            if (wr && (reg_sel == 2'd0) && !busy) begin
                ctrl_rw   <= wb_dat_i[1];
                ctrl_addr <= wb_dat_i[15:8];
            end
            if (wr && (reg_sel == 2'd1)) wdata <= wb_dat_i[7:0];

            // DONE setting the flag takes priority over a same-cycle clear.
            if (state == DONE)                                   done <= 1'b1;
            else if (start_cmd)                                  done <= 1'b0;
            else if (wr && (reg_sel == 2'd3) && wb_dat_i[1])     done <= 1'b0;

            if ((state == DONE) && !ctrl_rw) rdata <= rx;

            if ((state == IDLE) || (state == DONE) || last) cnt <= 8'h0;
            else                                            cnt <= cnt + 8'h1;

            if (start_cmd)
                shreg <= {(wb_dat_i[1] ? 8'h80 : 8'h40), wb_dat_i[15:8],
                          (wb_dat_i[1] ? wdata : 8'h00)};
            else if ((state == SHIFT) && last && phase)
                shreg <= {shreg[22:0], 1'b0};

            if ((state == SHIFT) && last && !phase) rx <= {rx[6:0], spi_sdo};

            if (state != SHIFT) begin
                phase   <= 1'b0;
                bit_cnt <= 5'd0;
            end else if (last) begin
                phase <= ~phase;
                if (phase) bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end
endmodule

// File: doc/hkspi_master_wb.md
Name: hkspi_master_wb

Overview:
- Wishbone-slave SPI master that drives the housekeeping SPI pins (CSB/SCK/SDI/SDO) from the management core.
- Lets firmware read and write housekeeping registers (PLL trim/select/divider, enables, IDs) without an external host.
- Sequences one single-byte register transfer per start command: 8-bit command, 8-bit address, 8-bit data.
- Sits beside spi_sysctrl_wb on the management Wishbone bus; its pins are muxed onto the housekeeping SPI slave inputs.

Parameters:
- BASE_ADR, 32'h2600_0000, Wishbone base address; register select uses wb_adr_i[3:2] when wb_adr_i[31:4] == BASE_ADR[31:4].
- CLK_DIV, 4, SCK half-period in wb_clk_i cycles. Legal range 1..255.

Ports:
- wb_clk_i  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- wb_stb_i  in  1  Wishbone strobe
- wb_cyc_i  in  1  Wishbone cycle
- wb_we_i  in  1  write enable
- wb_sel_i  in  4  byte selects; ignored, full-word access assumed
- wb_dat_i  in  32  write data
- wb_adr_i  in  32  address
- wb_ack_o  out  1  acknowledge
- wb_dat_o  out  32  read data
- spi_csb  out  1  chip select, active low
- spi_sck  out  1  serial clock
- spi_sdi  out  1  master-to-slave data
- spi_sdo  in  1  slave-to-master data
- irq  out  1  level interrupt, equals STATUS.done

Behaviour:
- **Reset values**: wb_ack_o=0, wb_dat_o=0, spi_csb=1, spi_sck=0, spi_sdi=0, irq=0. All registers are 0 and the FSM is in IDLE.
- **Wishbone access**:
  - A cycle is a hit when wb_stb_i & wb_cyc_i & address match.
  - wb_ack_o pulses for exactly one cycle, in the cycle after the hit is first seen.
  - wb_dat_o is valid with that ack.
  - No re-ack until stb drops.
  - A miss is never acked.
- **Registers** (byte offset):
  - 0x0 CTRL: [0] start (write-1, self-clearing, reads 0); [1] rw (1 = write); [15:8] addr.
  - 0x4 WDATA: [7:0].
  - 0x8 RDATA: [7:0], read-only.
  - 0xC STATUS: [0] busy (read-only); [1] done (sticky; write-1-to-clear).
  - Unused bits read 0.
- **Start**:
  - A CTRL write with bit0=1 while busy=0 latches rw, addr and WDATA into the shift register and clears done.
  - busy=1 from the next cycle.
  - A CTRL write while busy=1 is acked and fully ignored (rw/addr unchanged).
  - A WDATA write while busy does not affect the transfer in flight.
- **Frame**: 24 bits, MSB first. Command byte is 8'h80 when rw=1 and 8'h40 when rw=0, followed by addr, then WDATA (SDI = 0 for a read).
- **FSM**:
  - IDLE: start moves to SETUP and drives spi_csb=0.
  - SETUP: lasts CLK_DIV cycles; SDI presents bit 23; then SHIFT.
  - SHIFT: each bit is SCK low for CLK_DIV cycles, then SCK high for CLK_DIV cycles. spi_sdo is sampled into rx on the cycle SCK rises. SDI advances to the next bit on the SCK falling edge. After 24 bits SCK ends low and the FSM goes to HOLD.
  - HOLD: lasts CLK_DIV cycles; then spi_csb=1 and the FSM goes to DONE.
  - DONE: one cycle; RDATA = last 8 sampled bits (reads only; a write leaves RDATA unchanged); done=1; busy=0; back to IDLE.
- **Timing**:
  - Start ack cycle to busy falling = 50*CLK_DIV + 2 cycles.
  - Exactly 24 SCK rising edges per frame.
- **Simultaneous events**:
  - A done W1C in the same cycle that DONE sets done leaves done=1 (set wins).
  - A start write in the same cycle as DONE is ignored.
- **Reset mid-transfer**: outputs return immediately (asynchronously) to reset values, with no partial RDATA update. The next start runs a clean full frame.

Test Plan:
- Reset and register check:
  - Stimulus: assert resetb=0, release, then read all 4 registers.
  - Required: all read 0; spi_csb=1; spi_sck=0; irq=0.
- Write transfer:
  - Stimulus: CLK_DIV=4; write WDATA=0xA5; write CTRL = addr 0x12, rw=1, start.
  - Required: SDI bits captured on SCK rising edges are 0x80,0x12,0xA5; 24 edges; busy high for 202 cycles; done=1; irq=1; RDATA unchanged (0).
- Read transfer:
  - Stimulus: bench slave model returns 0x3C on SDO in the data byte; CTRL = addr 0x01, rw=0, start.
  - Required: command 0x40, address 0x01; RDATA=0x3C; done=1.
- Busy protection and W1C:
  - Stimulus: issue a second start (addr 0x77) mid-frame, then write STATUS=0x2 after completion.
  - Required: the second start is acked; the frame still carries addr 0x12; done clears to 0 and irq falls.
- Reset mid-frame:
  - Stimulus: drop resetb after 10 SCK edges.
  - Required: spi_csb=1 within the same cycle; busy=0; RDATA=0. A subsequent read frame completes normally.
- CLK_DIV=1 boundary:
  - Stimulus: read transfer with CLK_DIV=1.
  - Required: SCK toggles every cycle; busy lasts 52 cycles; RDATA correct.
